// File: rtl/mel_pkg.sv
// rtl/mel_pkg.sv - shared constants, FSM states and helpers for the mel filterbank
package mel_pkg;

    localparam int NMEL  = 40;
    localparam int NF    = 512;
    localparam int NBINS = 257;
    localparam int Q     = 15;
    localparam int ACC_W = 40;

    localparam logic [5:0] NO_FILTER = 6'd63;
    // Last bin covered by the synthetic table: 1 + 6 * (NMEL + 1) - 1.
    localparam logic [8:0] COEF_LAST = 9'd246;

    typedef enum logic [1:0] {ACCUM, FLUSH, EMIT, WAIT} state_e;

    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [33:0]      b);
        logic [ACC_W:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction

    // Six bins per band: half-weight edge, four full-weight bins, 1/4-weight tail.
    function automatic logic [21:0] mel_coef(input logic [8:0] bin);
        logic [8:0]  k;
        logic [15:0] wt;
        if (bin == 9'd0 || bin > COEF_LAST) begin
            return {NO_FILTER, 16'd0};
        end
        k = bin - 9'd1;
        case (k % 9'd6)
            9'd0:    wt = 16'd16384;
            9'd5:    wt = 16'd8192;
            default: wt = 16'd32768;
        endcase
        return {6'(k / 9'd6), wt};
    endfunction

endpackage

// File: rtl/mel_coef_rom.sv
// rtl/mel_coef_rom.sv - registered per-bin coefficient table {m, w}, 1-cycle latency
module mel_coef_rom
    import mel_pkg::*;
(
    input  logic        clk,
    input  logic [8:0]  bin,
    output logic [5:0]  m,
    output logic [15:0] w
);

    always_ff @(posedge clk) begin
        {m, w} <= mel_coef(bin);
    end

endmodule

// File: rtl/mel_filterbank.sv
// rtl/mel_filterbank.sv - triangular mel filterbank over a streamed periodogram
module mel_filterbank #(
    parameter int NMEL  = mel_pkg::NMEL,
    parameter int NF    = mel_pkg::NF,
    parameter int NBINS = mel_pkg::NBINS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] periodogram_in,
    input  logic        periodogram_valid,
    output logic [31:0] mel_out,
    output logic [5:0]  mel_index,
    output logic        mel_valid,
    output logic        overflow
);
    import mel_pkg::*;

    localparam logic [5:0] NMEL_M    = 6'(NMEL);
    localparam logic [5:0] LAST_BAND = 6'(NMEL - 1);
    localparam logic [8:0] LAST_BIN  = 9'(NBINS - 1);
    localparam logic [8:0] WRAP_BIN  = 9'(NF - 1);

    state_e      state_q, state_d;
    logic [1:0]  flush_cnt_q, flush_cnt_d;
    logic [5:0]  emit_idx_q, emit_idx_d;
    logic [8:0]  bin_q, bin_d;
    logic        in_frame;

    logic [5:0]  rom_m;
    logic [15:0] rom_w;
    logic        s1_valid_q;
    logic [31:0] s1_p_q;
    logic [16:0] w_lo, w_hi;
    logic [33:0] prod_lo, prod_hi;
    logic        s2_valid_q, s2_lo_en_q, s2_hi_en_q;
    logic [5:0]  s2_m_q;
    logic [33:0] s2_lo_q, s2_hi_q;

    logic [ACC_W-1:0] acc_q [NMEL];
    logic [ACC_W-1:0] acc_d [NMEL];
    logic [ACC_W-1:0] emit_acc;
    logic             emit_sat;
    logic             mel_valid_d, overflow_d;
    logic [5:0]       mel_index_d;
    logic [31:0]      mel_out_d;

    assign in_frame = (state_q == ACCUM) && ({1'b0, bin_q} < 10'(NBINS));
    assign bin_d    = !periodogram_valid ? bin_q :
                      (bin_q == WRAP_BIN) ? 9'd0 : bin_q + 9'd1;

    mel_coef_rom u_rom (
        .clk (clk),
        .bin (bin_q),
        .m   (rom_m),
        .w   (rom_w)
    );

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        emit_idx_d  = emit_idx_q;
        case (state_q)
            ACCUM: if (periodogram_valid && bin_q == LAST_BIN) begin
                state_d     = FLUSH;
                flush_cnt_d = 2'd0;
            end
            FLUSH: if (flush_cnt_q == 2'd2) begin
                state_d    = EMIT;
                emit_idx_d = 6'd0;
            end else begin
                flush_cnt_d = flush_cnt_q + 2'd1;
            end
            EMIT: if (emit_idx_q == LAST_BAND) begin
                state_d = WAIT;
            end else begin
                emit_idx_d = emit_idx_q + 6'd1;
            end
            WAIT: if (periodogram_valid && bin_q == WRAP_BIN) begin
                state_d = ACCUM;
            end
            default: state_d = ACCUM;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            flush_cnt_q <= '0;
            emit_idx_q  <= '0;
            bin_q       <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            emit_idx_q  <= emit_idx_d;
            bin_q       <= bin_d;
        end
    end

    // Rising weight goes to band m, the complementary falling weight to band m-1.
    assign w_lo    = {1'b0, rom_w};
    assign w_hi    = 17'd32768 - w_lo;
    assign prod_lo = 34'((49'(s1_p_q) * 49'(w_lo)) >> Q);
    assign prod_hi = 34'((49'(s1_p_q) * 49'(w_hi)) >> Q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_p_q     <= '0;
            s2_valid_q <= 1'b0;
            s2_lo_en_q <= 1'b0;
            s2_hi_en_q <= 1'b0;
            s2_m_q     <= '0;
            s2_lo_q    <= '0;
            s2_hi_q    <= '0;
        end else begin
            s1_valid_q <= periodogram_valid && in_frame;
            if (periodogram_valid) begin
                s1_p_q <= periodogram_in;
            end
            s2_valid_q <= s1_valid_q;
            s2_lo_en_q <= rom_m < NMEL_M;
            s2_hi_en_q <= (rom_m != 6'd0) && (rom_m <= NMEL_M);
            s2_m_q     <= rom_m;
            s2_lo_q    <= prod_lo;
            s2_hi_q    <= prod_hi;
        end
    end

    // Single-cycle read-modify-write on flops: a back-to-back hit on the same
    // band reads the value written on the previous edge, so nothing is lost.
    always_comb begin
        for (int i = 0; i < NMEL; i++) begin
            acc_d[i] = acc_q[i];
            if (s2_valid_q && s2_lo_en_q && s2_m_q == 6'(i)) begin
                acc_d[i] = sat_add(acc_q[i], s2_lo_q);
            end
            if (s2_valid_q && s2_hi_en_q && s2_m_q == 6'(i + 1)) begin
                acc_d[i] = sat_add(acc_q[i], s2_hi_q);
            end
            if (state_q == EMIT && emit_idx_q == 6'(i)) begin
                acc_d[i] = '0;
            end
        end
    end

    assign emit_acc    = acc_q[emit_idx_q];
    assign emit_sat    = |emit_acc[ACC_W-1:32];
    assign mel_valid_d = (state_q == EMIT);
    assign mel_index_d = mel_valid_d ? emit_idx_q : 6'd0;
    assign mel_out_d   = !mel_valid_d ? 32'd0 : emit_sat ? 32'hFFFF_FFFF : emit_acc[31:0];
    assign overflow_d  = overflow | (mel_valid_d & emit_sat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NMEL; i++) begin
                acc_q[i] <= '0;
            end
            mel_valid <= 1'b0;
            mel_index <= '0;
            mel_out   <= '0;
            overflow  <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mel_valid <= mel_valid_d;
            mel_index <= mel_index_d;
            mel_out   <= mel_out_d;
            overflow  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_mel_filterbank.sv
// tb/tb_mel_filterbank.sv - directed self-checking bench for mel_filterbank
module tb_mel_filterbank;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] periodogram_in;
    logic        periodogram_valid;
    logic [31:0] mel_out;
    logic [5:0]  mel_index;
    logic        mel_valid;
    logic        overflow;

    always #5 clk = ~clk;

    mel_filterbank dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .periodogram_in    (periodogram_in),
        .periodogram_valid (periodogram_valid),
        .mel_out           (mel_out),
        .mel_index         (mel_index),
        .mel_valid         (mel_valid),
        .overflow          (overflow)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc = 0;
    int nbeats = 0;
    logic [31:0] frame_p   [512];
    logic [31:0] exp_out   [40];
    logic [31:0] beat_val  [2048];
    logic [5:0]  beat_idx  [2048];
    int          beat_cyc  [2048];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mel_valid && nbeats < 2048) begin
            beat_val[nbeats] = mel_out;
            beat_idx[nbeats] = mel_index;
            beat_cyc[nbeats] = cyc;
            nbeats = nbeats + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1);
    end

    task automatic drive_frame(input int gap_pct);
        for (int b = 0; b < 512; b++) begin
            @(negedge clk);
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
                periodogram_valid = 1'b0;
                @(negedge clk);
            end
            periodogram_in    = frame_p[b];
            periodogram_valid = 1'b1;
            if (b == 256) accept_cyc = cyc + 1;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        periodogram_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic tb_coef(input int b, output int m, output int w);
        if (b == 0 || b > 246) begin
            m = 63;
            w = 0;
        end else begin
            m = (b - 1) / 6;
            w = ((b - 1) % 6 == 0) ? 16384 : ((b - 1) % 6 == 5) ? 8192 : 32768;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        periodogram_in = '0;
        periodogram_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (mel_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", mel_valid); end
        checks++; if (mel_out !== 32'd0) begin errors++; $display("FAIL reset_out got %h want 0", mel_out); end
        checks++; if (mel_index !== 6'd0) begin errors++; $display("FAIL reset_index got %0d want 0", mel_index); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_frame;
        int start;
        for (int b = 0; b < 512; b++) frame_p[b] = 32'd0;
        start = nbeats;
        drive_frame(0);
        idle(4);
        checks++; if (nbeats - start !== 40) begin errors++; $display("FAIL zero_beats got %0d want 40", nbeats - start); end
        for (int i = 0; i < 40 && start + i < nbeats; i++) begin
            checks++; if (beat_idx[start+i] !== 6'(i)) begin errors++; $display("FAIL zero_index beat %0d got %0d want %0d", i, beat_idx[start+i], i); end
            checks++; if (beat_val[start+i] !== 32'd0) begin errors++; $display("FAIL zero_out band %0d got %h want 0", i, beat_val[start+i]); end
        end
    endtask

    task automatic test_impulse(input string tag);
        int start;
        for (int b = 0; b < 512; b++) frame_p[b] = 32'd0;
        frame_p[31] = 32'h0001_0000;
        for (int i = 0; i < 40; i++) exp_out[i] = 32'd0;
        exp_out[5] = 32'h0000_8000;
        exp_out[4] = 32'h0000_8000;
        start = nbeats;
        drive_frame(0);
        idle(4);
        checks++; if (nbeats - start !== 40) begin errors++; $display("FAIL %s_beats got %0d want 40", tag, nbeats - start); end
        for (int i = 0; i < 40 && start + i < nbeats; i++) begin
            checks++; if (beat_val[start+i] !== exp_out[i] || beat_idx[start+i] !== 6'(i)) begin
                errors++; $display("FAIL %s band %0d got %h idx %0d want %h", tag, i, beat_val[start+i], beat_idx[start+i], exp_out[i]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int s1, s2, a1, a2;
        for (int b = 0; b < 512; b++) frame_p[b] = 32'h0001_0000;
        s1 = nbeats;
        drive_frame(0);
        a1 = accept_cyc;
        s2 = nbeats;
        drive_frame(0);
        a2 = accept_cyc;
        idle(4);
        checks++; if (s2 - s1 !== 40) begin errors++; $display("FAIL b2b_beats1 got %0d want 40", s2 - s1); end
        checks++; if (nbeats - s2 !== 40) begin errors++; $display("FAIL b2b_beats2 got %0d want 40", nbeats - s2); end
        if (s2 - s1 == 40 && nbeats - s2 == 40) begin
            checks++; if (beat_cyc[s1] - a1 !== 4) begin errors++; $display("FAIL b2b_latency1 got %0d want 4", beat_cyc[s1] - a1); end
            checks++; if (beat_cyc[s2] - a2 !== 4) begin errors++; $display("FAIL b2b_latency2 got %0d want 4", beat_cyc[s2] - a2); end
            for (int i = 0; i < 40; i++) begin
                checks++; if (beat_val[s1+i] !== 32'h0006_0000) begin errors++; $display("FAIL b2b_f1 band %0d got %h want 00060000", i, beat_val[s1+i]); end
                checks++; if (beat_val[s2+i] !== 32'h0006_0000) begin errors++; $display("FAIL b2b_f2 band %0d got %h want 00060000", i, beat_val[s2+i]); end
            end
        end
    endtask

    task automatic test_random_gaps;
        int start, m, w;
        longint unsigned e [40];
        for (int b = 0; b < 512; b++) frame_p[b] = $urandom & 32'h0FFF_FFFF;
        for (int i = 0; i < 40; i++) e[i] = 0;
        for (int b = 0; b < 257; b++) begin
            tb_coef(b, m, w);
            if (m < 40) e[m] += (longint'(frame_p[b]) * longint'(w)) >> 15;
            if (m > 0 && m <= 40) e[m-1] += (longint'(frame_p[b]) * longint'(32768 - w)) >> 15;
        end
        for (int i = 0; i < 40; i++) exp_out[i] = (e[i] > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : e[i][31:0];
        start = nbeats;
        drive_frame(50);
        idle(4);
        checks++; if (nbeats - start !== 40) begin errors++; $display("FAIL rand_beats got %0d want 40", nbeats - start); end
        for (int i = 0; i < 40 && start + i < nbeats; i++) begin
            checks++; if (beat_val[start+i] !== exp_out[i]) begin errors++; $display("FAIL rand band %0d got %h want %h", i, beat_val[start+i], exp_out[i]); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rand_ovf got %b want 0", overflow); end
    endtask

    task automatic test_saturation;
        int start;
        for (int b = 0; b < 512; b++) frame_p[b] = 32'hFFFF_FFFF;
        start = nbeats;
        drive_frame(0);
        idle(4);
        checks++; if (nbeats - start !== 40) begin errors++; $display("FAIL sat_beats got %0d want 40", nbeats - start); end
        for (int i = 0; i < 40 && start + i < nbeats; i++) begin
            checks++; if (beat_val[start+i] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat band %0d got %h want ffffffff", i, beat_val[start+i]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf got %b want 1", overflow); end
        for (int b = 0; b < 512; b++) frame_p[b] = 32'd0;
        start = nbeats;
        drive_frame(0);
        idle(4);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL sat_ovf_sticky got %b want 1", overflow); end
        for (int i = 0; i < 40 && start + i < nbeats; i++) begin
            checks++; if (beat_val[start+i] !== 32'd0) begin errors++; $display("FAIL sat_next band %0d got %h want 0", i, beat_val[start+i]); end
        end
    endtask

    task automatic test_reset_mid_emit;
        bit found = 1'b0;
        for (int b = 0; b < 257; b++) begin
            @(negedge clk);
            periodogram_in    = 32'h0000_1000;
            periodogram_valid = 1'b1;
        end
        @(negedge clk);
        periodogram_valid = 1'b0;
        for (int t = 0; t < 60 && !found; t++) begin
            @(negedge clk);
            #1;
            if (mel_valid && mel_index == 6'd20) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_band20 got none want band 20 within 60 cycles"); end
        rst_n = 1'b0;
        #1;
        checks++; if (mel_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", mel_valid); end
        checks++; if (mel_out !== 32'd0) begin errors++; $display("FAIL abort_out got %h want 0", mel_out); end
        checks++; if (mel_index !== 6'd0) begin errors++; $display("FAIL abort_index got %0d want 0", mel_index); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL abort_ovf got %b want 0", overflow); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        test_impulse("post_abort");
    endtask

    initial begin
        test_reset();
        test_zero_frame();
        test_impulse("impulse");
        test_back_to_back();
        test_random_gaps();
        test_saturation();
        test_reset_mid_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
